// File: rtl/system_keys_in.sv
// Avalon-MM push-button input port: 2-flop sync, per-bit debounce, sticky edge capture, maskable irq.
// Zero-wait-state reads; debounced change visible 2+DEBOUNCE_CYCLES clocks after a stable input change.
module system_keys_in #(
  parameter int                WIDTH           = 4,
  parameter int                DEBOUNCE_CYCLES = 50000,
  parameter int                EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0]  IDLE_LEVEL      = {WIDTH{1'b1}}
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  input  logic [WIDTH-1:0]  in_port,
  output logic [31:0]       readdata,
  output logic              irq
);

  localparam int             CW      = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] debounced;
  logic [WIDTH-1:0] debounced_q;
  logic [CW-1:0]    cnt [WIDTH];
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] irq_mask_next;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] edgecapture_next;
  logic             wr;
  logic             unused_bits;

  assign wr          = chipselect & ~write_n;
  assign unused_bits = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1       <= IDLE_LEVEL;
      sync2       <= IDLE_LEVEL;
      debounced   <= IDLE_LEVEL;
      debounced_q <= IDLE_LEVEL;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      sync1       <= in_port;
      sync2       <= sync1;
      debounced_q <= debounced;
      // Any disagreement that does not persist for the full window restarts the count.
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == debounced[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          debounced[i] <= sync2[i];
          cnt[i]       <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    edge_det = '0;
    case (EDGE_TYPE)
      0:       edge_det = debounced & ~debounced_q;
      1:       edge_det = ~debounced & debounced_q;
      default: edge_det = debounced ^ debounced_q;
    endcase
  end

  always_comb begin
    irq_mask_next    = irq_mask;
    edgecapture_next = edgecapture;
    if (wr && address == 2'd2) irq_mask_next = writedata[WIDTH-1:0];
    if (wr && address == 2'd3) edgecapture_next = edgecapture & ~writedata[WIDTH-1:0];
    // A new edge in the clearing cycle must not be lost.
    edgecapture_next = edgecapture_next | edge_det;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask    <= '0;
      edgecapture <= '0;
      irq         <= 1'b0;
    end else begin
      irq_mask    <= irq_mask_next;
      edgecapture <= edgecapture_next;
      irq         <= |(edgecapture_next & irq_mask_next);
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = debounced;
      2'd2:    readdata[WIDTH-1:0] = irq_mask;
      2'd3:    readdata[WIDTH-1:0] = edgecapture;
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_system_keys_in.sv
// Directed bench for system_keys_in with WIDTH=4, DEBOUNCE_CYCLES=4, falling-edge capture.
module tb_system_keys_in;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [3:0]  in_port = 4'hF;
  logic [31:0] readdata;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;

  system_keys_in #(
    .WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .IDLE_LEVEL(4'hF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(tag, readdata, exp);
  endtask

  initial begin
    // 1: reset state
    @(negedge clk);
    reset_n = 1'b1;
    step(2);
    read_check("rst_data", 2'd0, 32'h0000_000F);
    read_check("rst_dir",  2'd1, 32'h0);
    read_check("rst_mask", 2'd2, 32'h0);
    read_check("rst_ecap", 2'd3, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_write(2'd0, 32'h0000_0000);
    read_check("dir_ro",  2'd1, 32'h0);
    read_check("data_ro", 2'd0, 32'h0000_000F);

    // 2: three-cycle glitch is rejected
    in_port = 4'hE;
    step(3);
    in_port = 4'hF;
    step(8);
    read_check("glitch_data", 2'd0, 32'hF);
    read_check("glitch_ecap", 2'd3, 32'h0);
    check("glitch_irq", {31'b0, irq}, 32'h0);

    // 3: held low, exact latency, capture, mask -> irq
    in_port = 4'hE;
    step(5);
    read_check("lat5_data", 2'd0, 32'hF);
    step(1);
    read_check("lat6_data", 2'd0, 32'hE);
    step(1);
    read_check("cap_ecap", 2'd3, 32'h1);
    check("cap_irq_masked", {31'b0, irq}, 32'h0);
    bus_write(2'd2, 32'h1);
    check("mask_irq", {31'b0, irq}, 32'h1);
    read_check("mask_rd", 2'd2, 32'h1);

    // 4: clear, then rising edge is not captured
    bus_write(2'd3, 32'h1);
    read_check("clr_ecap", 2'd3, 32'h0);
    check("clr_irq", {31'b0, irq}, 32'h0);
    in_port = 4'hF;
    step(10);
    read_check("rise_data", 2'd0, 32'hF);
    read_check("rise_ecap", 2'd3, 32'h0);
    check("rise_irq", {31'b0, irq}, 32'h0);

    // 5: set wins over coincident clear
    bus_write(2'd2, 32'h4);
    check("m4_irq", {31'b0, irq}, 32'h0);
    in_port = 4'hB;
    step(6);
    bus_write(2'd3, 32'h4);
    read_check("setwin_ecap", 2'd3, 32'h4);
    check("setwin_irq", {31'b0, irq}, 32'h1);
    read_check("setwin_data", 2'd0, 32'hB);

    // 6: capture bit 1, then async reset mid-debounce of bit 3
    bus_write(2'd3, 32'h4);
    check("b2clr_irq", {31'b0, irq}, 32'h0);
    bus_write(2'd2, 32'h2);
    in_port = 4'h9;
    step(7);
    read_check("b1_ecap", 2'd3, 32'h2);
    check("b1_irq", {31'b0, irq}, 32'h1);
    in_port = 4'h3;
    step(4);
    reset_n = 1'b0;
    #1;
    check("arst_irq", {31'b0, irq}, 32'h0);
    read_check("arst_ecap", 2'd3, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    read_check("post_data", 2'd0, 32'hF);
    read_check("post_mask", 2'd2, 32'h0);
    read_check("post_ecap", 2'd3, 32'h0);
    check("post_irq", {31'b0, irq}, 32'h0);
    step(5);
    read_check("post5_data", 2'd0, 32'hF);
    step(1);
    read_check("post6_data", 2'd0, 32'h3);
    step(1);
    read_check("post7_ecap", 2'd3, 32'hC);
    check("post7_irq", {31'b0, irq}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
